// File: rtl/lsu_mem_master_pkg.sv
// Shared types and helpers for the LSU memory master: access size codes, FSM states,
// the byte-mask decoder and the natural-alignment check.
package lsu_pkg;

    localparam int BEAT_BYTES = 8;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Byte-length mask; stores are never shifted, so the mask always starts at lane 0.
    function automatic logic [7:0] size_to_mask(input size_e size);
        logic [7:0] mask;
        case (size)
            SZ_B:    mask = 8'h01;
            SZ_H:    mask = 8'h03;
            SZ_W:    mask = 8'h0F;
            SZ_D:    mask = 8'hFF;
            default: mask = 8'h00;
        endcase
        return mask;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] addr_lo, input size_e size);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = addr_lo[0];
            SZ_W:    mis = |addr_lo[1:0];
            SZ_D:    mis = |addr_lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Request, response and memory-port signals between the core LSU, the memory master
// and the DPI-C memory model.
interface lsu_mem_master_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [1:0]        req_size;
    logic              req_unsigned;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_misalign;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              we_en;
    logic [ADDR_W-1:0] we_addr;
    logic [DATA_W-1:0] we_data;
    logic [7:0]        we_mask;

    modport master (
        input  req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
        input  resp_ready, rd_data,
        output req_ready, resp_valid, resp_rdata, resp_misalign,
        output rd_en, rd_addr, we_en, we_addr, we_data, we_mask
    );

    modport slave (
        output req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
        output resp_ready, rd_data,
        input  req_ready, resp_valid, resp_rdata, resp_misalign,
        input  rd_en, rd_addr, we_en, we_addr, we_data, we_mask
    );
endinterface

// File: rtl/lsu_mem_master_load_extend.sv
// Selects the low 1/2/4/8 bytes of a memory beat and sign- or zero-extends them.
module lsu_load_extend
    import lsu_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] rd_data,
    input  size_e             size,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] ext_data
);

    logic fill_b_s;
    logic fill_h_s;
    logic fill_w_s;

    assign fill_b_s = ~is_unsigned & rd_data[7];
    assign fill_h_s = ~is_unsigned & rd_data[15];
    assign fill_w_s = ~is_unsigned & rd_data[31];

    // Width select and extension.
    always_comb begin
        ext_data = {DATA_W{1'b0}};
        case (size)
            SZ_B:    ext_data = {{(DATA_W-8){fill_b_s}},  rd_data[7:0]};
            SZ_H:    ext_data = {{(DATA_W-16){fill_h_s}}, rd_data[15:0]};
            SZ_W:    ext_data = {{(DATA_W-32){fill_w_s}}, rd_data[31:0]};
            SZ_D:    ext_data = rd_data;
            default: ext_data = {DATA_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store initiator for the DPI-C memory port. Each accepted request
// produces exactly one single-cycle rd_en or we_en strobe and one registered response.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int CHECK_ALIGN = 1
) (
    input  logic             clock,
    input  logic             reset,
    lsu_mem_master_if.master bus
);

    state_e            state_r;
    size_e             size_r;
    logic              uns_r;
    logic              wen_r;

    logic              req_ready_r;
    logic              resp_valid_r;
    logic [DATA_W-1:0] resp_rdata_r;
    logic              resp_misalign_r;
    logic              rd_en_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic              we_en_r;
    logic [ADDR_W-1:0] we_addr_r;
    logic [DATA_W-1:0] we_data_r;
    logic [7:0]        we_mask_r;

    logic [DATA_W-1:0] ext_data_s;
    logic              reject_s;
    size_e             req_size_s;

    assign req_size_s = size_e'(bus.req_size);
    assign reject_s   = (CHECK_ALIGN != 0) && is_misaligned(bus.req_addr[2:0], req_size_s);

    lsu_load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .rd_data     (bus.rd_data),
        .size        (size_r),
        .is_unsigned (uns_r),
        .ext_data    (ext_data_s)
    );

    // Request/strobe/response FSM; every output below is a flop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            size_r          <= SZ_B;
            uns_r           <= 1'b0;
            wen_r           <= 1'b0;
            req_ready_r     <= 1'b0;
            resp_valid_r    <= 1'b0;
            resp_rdata_r    <= {DATA_W{1'b0}};
            resp_misalign_r <= 1'b0;
            rd_en_r         <= 1'b0;
            rd_addr_r       <= {ADDR_W{1'b0}};
            we_en_r         <= 1'b0;
            we_addr_r       <= {ADDR_W{1'b0}};
            we_data_r       <= {DATA_W{1'b0}};
            we_mask_r       <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    req_ready_r <= 1'b1;
                    if (bus.req_valid && req_ready_r) begin
                        req_ready_r <= 1'b0;
                        size_r      <= req_size_s;
                        uns_r       <= bus.req_unsigned;
                        wen_r       <= bus.req_wen;
                        if (reject_s) begin
                            // Rejected requests never reach the memory port.
                            state_r         <= ST_RESP;
                            resp_valid_r    <= 1'b1;
                            resp_misalign_r <= 1'b1;
                            resp_rdata_r    <= {DATA_W{1'b0}};
                        end else if (bus.req_wen) begin
                            state_r   <= ST_ACCESS;
                            we_en_r   <= 1'b1;
                            we_addr_r <= bus.req_addr;
                            we_data_r <= bus.req_wdata;
                            we_mask_r <= size_to_mask(req_size_s);
                        end else begin
                            state_r   <= ST_ACCESS;
                            rd_en_r   <= 1'b1;
                            rd_addr_r <= bus.req_addr;
                        end
                    end
                end
                ST_ACCESS: begin
                    // rd_data is combinational from rd_addr, so it is valid in this cycle.
                    rd_en_r         <= 1'b0;
                    rd_addr_r       <= {ADDR_W{1'b0}};
                    we_en_r         <= 1'b0;
                    we_addr_r       <= {ADDR_W{1'b0}};
                    we_data_r       <= {DATA_W{1'b0}};
                    we_mask_r       <= 8'h00;
                    resp_valid_r    <= 1'b1;
                    resp_misalign_r <= 1'b0;
                    resp_rdata_r    <= wen_r ? {DATA_W{1'b0}} : ext_data_s;
                    state_r         <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_r    <= 1'b0;
                        resp_misalign_r <= 1'b0;
                        resp_rdata_r    <= {DATA_W{1'b0}};
                        req_ready_r     <= 1'b1;
                        state_r         <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    req_ready_r  <= 1'b0;
                    resp_valid_r <= 1'b0;
                    rd_en_r      <= 1'b0;
                    we_en_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready     = req_ready_r;
    assign bus.resp_valid    = resp_valid_r;
    assign bus.resp_rdata    = resp_rdata_r;
    assign bus.resp_misalign = resp_misalign_r;
    assign bus.rd_en         = rd_en_r;
    assign bus.rd_addr       = rd_addr_r;
    assign bus.we_en         = we_en_r;
    assign bus.we_addr       = we_addr_r;
    assign bus.we_data       = we_data_r;
    assign bus.we_mask       = we_mask_r;

endmodule
